// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - credit-based command issuer for a fixed-latency pipelined ALU
module alu_cmd_issuer #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 2,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shift,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = WIDTH + 3 + TAG_W;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ALU_LATENCY:0] pipe_valid;
  logic [TAG_W-1:0]   pipe_tag [ALU_LATENCY+1];
  logic               accept;
  logic               pop;
  logic               capture;
  logic [ENT_W-1:0]   head;

  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign capture   = pipe_valid[ALU_LATENCY];
  // Credits cover every op from issue until its response is popped, so the FIFO never overflows.
  assign cmd_ready = (outstanding < FULL);
  assign rsp_valid = (fifo_count != '0);
  assign busy      = (outstanding != '0);
  assign head      = mem[rd_ptr];
  assign {rsp_result, rsp_carry, rsp_zero, rsp_sign, rsp_tag} = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end else if (accept) begin
      alu_opcode     <= cmd_opcode;
      alu_input1     <= cmd_a;
      alu_input2     <= cmd_b;
      alu_shiftValue <= cmd_shift;
    end
  end

  // Stage ALU_LATENCY lines up with the ALU result for the op issued that many edges earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i <= ALU_LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_valid  <= {pipe_valid[ALU_LATENCY-1:0], accept};
      pipe_tag[0] <= cmd_tag;
      for (int i = 1; i <= ALU_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= {alu_result, alu_carry, alu_zero, alu_sign, pipe_tag[ALU_LATENCY]};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
